load_store_unit: RTL and testbench

- Sits between the CPU datapath and the word-addressed data memory (10-bit word address, 32-bit data, combinational read, write on posedge clk when write-enable is high).
- Converts byte-addressed byte/half/word loads and stores into memory word accesses.
- Sub-word stores use a read-modify-write sequence; loads are sign- or zero-extended.
- Uses a valid/ready request handshake and a one-cycle response pulse; misaligned accesses raise resp_err.

---
 rtl/load_store_unit_pkg.sv | 25 ++
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit_byte_lane_align.sv | 36 +++
 rtl/load_store_unit.sv | 112 +++++++++++
 tb/tb_load_store_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states
// and the alignment rule used when a request is accepted.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2
    } lsu_state_t;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        return (size == SZ_RSVD)
            || (size == SZ_HALF && lo[0])
            || (size == SZ_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// The slave side is the unit; the master side is the CPU plus memory.
interface lsu_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed,
        input  req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed,
        output req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit_byte_lane_align.sv
// Little-endian lane steering: extends a load lane out of a memory word
// and merges a byte/half store into it for read-modify-write.
module byte_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Select the addressed lane, then extend it or overwrite it.
    always_comb begin
        lane_b   = word[{off, 3'b000} +: 8];
        lane_h   = off[1] ? word[31:16] : word[15:0];
        load_val = word;
        merged   = word;
        case (size)
            SZ_BYTE: begin
                load_val = {{24{sgn & lane_b[7]}}, lane_b};
                merged[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_val = {{16{sgn & lane_h[15]}}, lane_h};
                if (off[1]) merged[31:16] = wdata;
                else        merged[15:0]  = wdata;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory.
// Define LSU_BOUNDS_CHECK_EN to fault addresses above the memory window.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input logic   clk,
    input logic   reset,
    lsu_if.slave  bus
);
`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
`endif

    lsu_state_t        state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W+1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_merged;
    logic              r_err;
    logic              upper_nz;
    logic              req_err;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] merged;

    assign upper_nz = |bus.req_addr[31:ADDR_W+2];
    assign req_err  = misaligned(bus.req_size, bus.req_addr[1:0])
                    | (BOUNDS_CHECK & upper_nz);

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_addr  = r_addr[ADDR_W+1:2];
    assign bus.mem_wdata = (state == WRITE) ? r_merged : r_wdata;
    assign bus.mem_we    = (state == WRITE)
                        || (state == ACCESS && r_we && !r_err
                            && r_size == SZ_WORD);

    byte_lane_align u_align (
        .size     (r_size),
        .sgn      (r_signed),
        .off      (r_addr[1:0]),
        .word     (bus.mem_rdata),
        .wdata    (r_wdata[15:0]),
        .load_val (load_val),
        .merged   (merged)
    );

    // Request FSM: accept, access memory, optional write-back, respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            r_we           <= 1'b0;
            r_size         <= SZ_BYTE;
            r_signed       <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_merged       <= '0;
            r_err          <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we     <= bus.req_we;
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        r_addr   <= bus.req_addr[ADDR_W+1:0];
                        r_wdata  <= bus.req_wdata;
                        r_err    <= req_err;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_err) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= '0;
                        state          <= IDLE;
                    end else if (!r_we) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= load_val;
                        state          <= IDLE;
                    end else if (r_size == SZ_WORD) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= '0;
                        state          <= IDLE;
                    end else begin
                        r_merged <= merged;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a
// queue of expected responses popped as each resp_valid arrives.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [31:0] mem [0:1023];

    lsu_if #(.ADDR_W(10)) bus ();

    load_store_unit #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(
        input string       tag,
        input logic        we,
        input logic [1:0]  size,
        input logic        sgn,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] exp_rdata,
        input logic        exp_err,
        input int          exp_lat,
        input int          exp_we_n,
        input int          exp_busy_n
    );
        exp_t e;
        int   we_n;
        int   busy_n;
        bit   got;
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        check({tag, "_idle_resp"}, {31'd0, bus.resp_valid}, 32'd0);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        sb.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h0;
        bus.req_size  = SZ_RSVD;
        we_n   = 0;
        busy_n = 0;
        got    = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            if (bus.mem_we) we_n++;
            if (!bus.req_ready) busy_n++;
            if (bus.resp_valid) begin
                got = 1'b1;
                e = sb.pop_front();
                check({tag, "_rdata"}, bus.resp_rdata, e.rdata);
                check({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, e.err});
                check({tag, "_lat"}, c, e.lat);
            end
        end
        check({tag, "_resp_seen"}, {31'd0, got}, 32'd1);
        check({tag, "_we_cycles"}, we_n, exp_we_n);
        check({tag, "_busy_cycles"}, busy_n, exp_busy_n);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = SZ_WORD;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        #12;
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_err", {31'd0, bus.resp_err}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", {22'd0, bus.mem_addr}, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        do_req("sw0", 1, SZ_WORD, 0, 32'h000, 32'hCAFE_0001,
               32'h0, 0, 2, 1, 1);
        check("mem0", mem[0], 32'hCAFE_0001);

        do_req("sw_dead", 1, SZ_WORD, 0, 32'h010, 32'hDEAD_BEEF,
               32'h0, 0, 2, 1, 1);
        check("mem4_dead", mem[4], 32'hDEAD_BEEF);
        do_req("lw_dead", 0, SZ_WORD, 0, 32'h010, 32'h0,
               32'hDEAD_BEEF, 0, 2, 0, 1);

        do_req("sw_1122", 1, SZ_WORD, 0, 32'h010, 32'h1122_3344,
               32'h0, 0, 2, 1, 1);
        do_req("lb_s13", 0, SZ_BYTE, 1, 32'h013, 32'h0,
               32'h0000_0011, 0, 2, 0, 1);
        do_req("lh_s12", 0, SZ_HALF, 1, 32'h012, 32'h0,
               32'h0000_1122, 0, 2, 0, 1);
        do_req("lbu_10", 0, SZ_BYTE, 0, 32'h010, 32'h0,
               32'h0000_0044, 0, 2, 0, 1);
        do_req("lhu_10", 0, SZ_HALF, 0, 32'h010, 32'h0,
               32'h0000_3344, 0, 2, 0, 1);

        do_req("sw_80ff", 1, SZ_WORD, 0, 32'h010, 32'h80FF_0000,
               32'h0, 0, 2, 1, 1);
        do_req("lb_s12", 0, SZ_BYTE, 1, 32'h012, 32'h0,
               32'hFFFF_FFFF, 0, 2, 0, 1);
        do_req("lbu_12", 0, SZ_BYTE, 0, 32'h012, 32'h0,
               32'h0000_00FF, 0, 2, 0, 1);
        do_req("lh_s12n", 0, SZ_HALF, 1, 32'h012, 32'h0,
               32'hFFFF_80FF, 0, 2, 0, 1);
        do_req("lb_s13n", 0, SZ_BYTE, 1, 32'h013, 32'h0,
               32'hFFFF_FF80, 0, 2, 0, 1);

        do_req("sw_rst", 1, SZ_WORD, 0, 32'h010, 32'h1122_3344,
               32'h0, 0, 2, 1, 1);
        do_req("sb_11", 1, SZ_BYTE, 0, 32'h011, 32'hFFFF_FFAB,
               32'h0, 0, 3, 1, 2);
        check("mem4_sb", mem[4], 32'h1122_AB44);
        do_req("sh_12", 1, SZ_HALF, 0, 32'h012, 32'h1234_BEEF,
               32'h0, 0, 3, 1, 2);
        check("mem4_sh", mem[4], 32'hBEEF_AB44);

        do_req("err_lh11", 0, SZ_HALF, 1, 32'h011, 32'h0,
               32'h0, 1, 2, 0, 1);
        do_req("err_sw12", 1, SZ_WORD, 0, 32'h012, 32'h5555_5555,
               32'h0, 1, 2, 0, 1);
        do_req("err_rsvd", 1, SZ_RSVD, 0, 32'h010, 32'h6666_6666,
               32'h0, 1, 2, 0, 1);
        check("mem4_err", mem[4], 32'hBEEF_AB44);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_BYTE;
        bus.req_addr  = 32'h010;
        bus.req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_we_write", {31'd0, bus.mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_we_drop", {31'd0, bus.mem_we}, 32'd0);
        check("mid_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid_mem4", mem[4], 32'hBEEF_AB44);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_no_resp", {31'd0, bus.resp_valid}, 32'd0);
            check("mid_ready_after", {31'd0, bus.req_ready}, 32'd1);
        end

`ifdef LSU_BOUNDS_CHECK_EN
        do_req("bounds", 0, SZ_WORD, 0, 32'h0000_1000, 32'h0,
               32'h0, 1, 2, 0, 1);
`else
        do_req("bounds", 0, SZ_WORD, 0, 32'h0000_1000, 32'h0,
               32'hCAFE_0001, 0, 2, 0, 1);
`endif
        check("mem0_final", mem[0], 32'hCAFE_0001);
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
